dram_cmd_sched: RTL and testbench
=================================

DRAM_CMD_SCHED -- requirements
Module: dram_cmd_sched

Interface
REQ-001 SHALL have parameter NUM_OF_BANKS, default 8, number of DRAM banks.
REQ-002 SHALL have parameter NUM_OF_ROWS, default 128, rows per bank.
REQ-003 SHALL have parameter NUM_OF_COLS, default 8, columns per row.
REQ-004 SHALL have parameter REF_INTERVAL, default 1024, clock cycles between refresh requests.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk (input, 1) is the sole clock; rst_b (input, 1) is the asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, access request present.
REQ-007 SHALL have port req_ready, output, 1, scheduler accepts a request this cycle.
REQ-008 SHALL have port req_rw, input, 1, access type: 1 = write, 0 = read.
REQ-009 SHALL have ports req_bank, req_row, req_col, inputs, widths clog2(NUM_OF_BANKS), clog2(NUM_OF_ROWS) and clog2(NUM_OF_COLS), target address.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when an accepted access completes.
REQ-011 SHALL have port cmd_req, output, 1, command request to the DRAM model.
REQ-012 SHALL have port cmd_ack, input, 1, command acknowledge from the DRAM model.
REQ-013 SHALL have port cmd, output, 2, command code: 00 = ACT, 01 = RD, 10 = WR, 11 = PRE.
REQ-014 SHALL have ports bank_id, row_id, col_id, outputs, same widths as req_bank, req_row and req_col, command address.
REQ-015 SHALL have port open_mask, output, NUM_OF_BANKS, bit b set while bank b has an open row.
REQ-016 SHALL have port ref_busy, output, 1, high while a refresh precharge sweep is in progress.

Function
REQ-017 SHALL implement states IDLE, ISSUE, RELEASE and REF_SCAN.
REQ-018 SHALL drive req_ready = 1 only in IDLE with no refresh pending.
REQ-019 SHALL capture req_* on a clk edge where req_valid && req_ready, then enter ISSUE on the next cycle.
REQ-020 SHALL build the command sequence from the open-row table at accept time:
- row hit (bank open, same row): RD or WR.
- row miss (bank open, different row): PRE, ACT, RD or WR.
- bank closed: ACT, RD or WR.
REQ-021 SHALL hold cmd_req = 1 in ISSUE, with cmd, bank_id, row_id and col_id stable until cmd_ack is sampled 1; then go to RELEASE.
REQ-022 SHALL hold cmd_req = 0 in RELEASE until cmd_ack is sampled 0, then:
- go to ISSUE for the next command in the sequence, or
- go to IDLE and pulse done for exactly one cycle when the sequence is finished.
REQ-023 SHALL update the open-row table on the cycle cmd_ack is sampled 1:
- ACT sets open_mask[bank] and stores row_id.
- PRE clears open_mask[bank].
- RD/WR leave the table unchanged (open-page policy).
REQ-024 SHALL run a refresh counter that counts 0..REF_INTERVAL-1 every cycle and wraps; on wrap it sets refresh-pending, and further wraps while pending do not stack.
REQ-025 SHALL give refresh priority over req_valid when both are present in IDLE.
REQ-026 SHALL handle a pending refresh in IDLE as follows:
- enter REF_SCAN with ref_busy = 1.
- issue PRE to each open bank in ascending bank order using the ISSUE/RELEASE handshake.
- clear pending and ref_busy and return to IDLE when open_mask = 0.
- pulse no done.
REQ-027 SHALL, on refresh with open_mask = 0, spend exactly one REF_SCAN cycle and then return to IDLE.
REQ-028 SHALL not preempt an access sequence in progress; a refresh wrap during an access only sets pending.
REQ-029 SHALL drive col_id = 0 for ACT and PRE, and row_id = 0 for RD, WR and PRE.
REQ-030 SHALL, when cmd_ack = 1 is already present on entry to ISSUE, assert cmd_req for at least one cycle before moving to RELEASE.

Reset
REQ-031 SHALL, on rst_b = 0, immediately and asynchronously force:
- state IDLE.
- cmd_req = 0, cmd = 00, bank_id/row_id/col_id = 0.
- done = 0, ref_busy = 0, req_ready = 0, open_mask = 0.
- refresh counter = 0, pending = 0.
REQ-032 SHALL discard any in-flight sequence on reset assertion mid-operation and not resume it after release.
REQ-033 SHALL raise req_ready on the first clk edge after rst_b rises.

Verification
REQ-034 Closed bank write: bank 2, row 5, col 3, rw = 1, with ack following req by 1 cycle -> commands ACT(2,5), then WR(2,col 3); open_mask = 0x04; one done pulse.
REQ-035 Row hit then miss:
- read bank 2 row 5 -> only RD.
- read bank 2 row 9 -> PRE(2), ACT(2,9), RD; open_mask stays 0x04.
REQ-036 Refresh sweep: REF_INTERVAL = 64, banks 1 and 6 open, req_valid held high -> on wrap, PRE(1) then PRE(6); ref_busy high throughout; open_mask = 0; request accepted only after the sweep.
REQ-037 Refresh wrap during an access sequence -> sequence completes with done, then the sweep starts from IDLE.
REQ-038 Reset mid-ISSUE: assert rst_b = 0 while cmd_req = 1 -> cmd_req = 0 in the same cycle; open_mask = 0; no done pulse after release.
REQ-039 Stuck-high ack: cmd_ack held at 1 for 5 cycles in RELEASE -> no new command issued until ack drops.

Source files
------------

// File: rtl/dram_cmd_sched.sv
// -----------------------------------------------------------------------------
// dram_cmd_sched
// Open-page DRAM command scheduler. Each accepted access is turned into a
// short command sequence (PRE/ACT/RD/WR), chosen from the open-row table at
// accept time. Every command goes out over a four-phase req/ack handshake.
// A free-running refresh counter raises a refresh request on every wrap.
// The request is serviced from IDLE by precharging every open bank, in
// ascending bank order.
//
// Ports
//   clk, rst_b             clock, asynchronous active-low reset
//   req_valid/req_ready    access request handshake
//   req_rw                 1 = write, 0 = read
//   req_bank/row/col       access address
//   done                   one-cycle pulse when an access sequence finishes
//   cmd_req/cmd_ack        command handshake to the DRAM model
//   cmd                    00 ACT, 01 RD, 10 WR, 11 PRE
//   bank_id/row_id/col_id  command address
//   open_mask              bit b set while bank b has an open row
//   ref_busy               high during a refresh precharge sweep
// -----------------------------------------------------------------------------
module dram_cmd_sched #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int REF_INTERVAL = 1024
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_rw,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row,
  input  logic [$clog2(NUM_OF_COLS)-1:0]  req_col,
  output logic                            done,
  output logic                            cmd_req,
  input  logic                            cmd_ack,
  output logic [1:0]                      cmd,
  output logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
  output logic [$clog2(NUM_OF_COLS)-1:0]  col_id,
  output logic [NUM_OF_BANKS-1:0]         open_mask,
  output logic                            ref_busy
);

  localparam int BANK_W = $clog2(NUM_OF_BANKS);
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int COL_W  = $clog2(NUM_OF_COLS);
  localparam int CNT_W  = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, REF_SCAN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    ref_cnt;
  logic                ref_pend;
  logic                ref_wrap;

  // Captured access and its remaining sequence steps.
  logic                cur_rw;
  logic [BANK_W-1:0]   cur_bank;
  logic [ROW_W-1:0]    cur_row;
  logic [COL_W-1:0]    cur_col;
  logic                need_pre;
  logic                need_act;
  logic                access_done;

  logic [ROW_W-1:0]    open_row [NUM_OF_BANKS];

  logic                acc_open;
  logic                acc_hit;
  logic [1:0]          first_cmd;
  logic [1:0]          next_cmd;
  logic [BANK_W-1:0]   scan_bank;

  // Only ACT carries a row and only RD/WR carry a column; others drive zero.
  function automatic logic [ROW_W-1:0] row_field(input logic [1:0] c,
                                                 input logic [ROW_W-1:0] r);
    return (c == CMD_ACT) ? r : '0;
  endfunction

  function automatic logic [COL_W-1:0] col_field(input logic [1:0] c,
                                                 input logic [COL_W-1:0] k);
    return (c == CMD_RD || c == CMD_WR) ? k : '0;
  endfunction

  assign ref_wrap = (ref_cnt == CNT_W'(REF_INTERVAL - 1));

  // Row-hit / row-miss classification of the incoming request.
  assign acc_open  = open_mask[req_bank];
  assign acc_hit   = acc_open && (open_row[req_bank] == req_row);
  assign first_cmd = (acc_open && !acc_hit) ? CMD_PRE :
                     (!acc_hit)             ? CMD_ACT :
                     (req_rw ? CMD_WR : CMD_RD);

  // Next step of the sequence in flight; the step flags are cleared as acked.
  assign next_cmd  = need_pre ? CMD_PRE :
                     need_act ? CMD_ACT :
                     (cur_rw ? CMD_WR : CMD_RD);

  // Lowest-numbered open bank, for the ascending refresh sweep.
  always_comb begin
    scan_bank = '0;
    for (int i = NUM_OF_BANKS - 1; i >= 0; i--) begin
      if (open_mask[i]) scan_bank = BANK_W'(i);
    end
  end

  // The row table needs no reset: entries are only read where open_mask is set.
  always_ff @(posedge clk) begin
    if (state == ISSUE && cmd_ack && cmd == CMD_ACT) begin
      open_row[bank_id] <= row_id;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      cmd_req     <= 1'b0;
      cmd         <= CMD_ACT;
      bank_id     <= '0;
      row_id      <= '0;
      col_id      <= '0;
      done        <= 1'b0;
      ref_busy    <= 1'b0;
      req_ready   <= 1'b0;
      open_mask   <= '0;
      ref_cnt     <= '0;
      ref_pend    <= 1'b0;
      cur_rw      <= 1'b0;
      cur_bank    <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      need_pre    <= 1'b0;
      need_act    <= 1'b0;
      access_done <= 1'b0;
    end else begin
      done    <= 1'b0;
      ref_cnt <= ref_wrap ? '0 : ref_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (ref_pend) begin
            state     <= REF_SCAN;
            ref_busy  <= 1'b1;
            req_ready <= 1'b0;
          end else if (req_valid && req_ready) begin
            cur_rw      <= req_rw;
            cur_bank    <= req_bank;
            cur_row     <= req_row;
            cur_col     <= req_col;
            need_pre    <= acc_open && !acc_hit;
            need_act    <= !acc_hit;
            access_done <= 1'b0;
            cmd         <= first_cmd;
            bank_id     <= req_bank;
            row_id      <= row_field(first_cmd, req_row);
            col_id      <= col_field(first_cmd, req_col);
            cmd_req     <= 1'b1;
            req_ready   <= 1'b0;
            state       <= ISSUE;
          end else begin
            // A wrap this cycle makes refresh pending next cycle.
            req_ready <= !ref_wrap;
          end
        end

        ISSUE: begin
          // cmd_req is already high here, so an early ack still sees a request.
          if (cmd_ack) begin
            cmd_req <= 1'b0;
            state   <= RELEASE;
            case (cmd)
              CMD_ACT: begin
                open_mask[bank_id] <= 1'b1;
                need_act           <= 1'b0;
              end
              CMD_PRE: begin
                open_mask[bank_id] <= 1'b0;
                need_pre           <= 1'b0;
              end
              default: access_done <= 1'b1;
            endcase
          end
        end

        RELEASE: begin
          if (!cmd_ack) begin
            if (ref_busy) begin
              state <= REF_SCAN;
            end else if (access_done) begin
              state     <= IDLE;
              done      <= 1'b1;
              req_ready <= !(ref_wrap || ref_pend);
            end else begin
              cmd     <= next_cmd;
              bank_id <= cur_bank;
              row_id  <= row_field(next_cmd, cur_row);
              col_id  <= col_field(next_cmd, cur_col);
              cmd_req <= 1'b1;
              state   <= ISSUE;
            end
          end
        end

        REF_SCAN: begin
          if (open_mask == '0) begin
            ref_busy  <= 1'b0;
            ref_pend  <= 1'b0;
            state     <= IDLE;
            req_ready <= !ref_wrap;
          end else begin
            cmd     <= CMD_PRE;
            bank_id <= scan_bank;
            row_id  <= '0;
            col_id  <= '0;
            cmd_req <= 1'b1;
            state   <= ISSUE;
          end
        end

        default: state <= IDLE;
      endcase

      // Set last so a wrap coinciding with the end of a sweep is not lost.
      if (ref_wrap) ref_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_dram_cmd_sched
// Directed bench for dram_cmd_sched. It uses REF_INTERVAL = 64.
// Expected commands are queued when a request is driven, or when the bench's
// own refresh counter wraps. They are popped as the DUT raises cmd_req.
// A small DRAM responder acknowledges each command about one cycle after the
// request. It can hold ack high for extra cycles.
// -----------------------------------------------------------------------------
module tb_dram_cmd_sched;

  localparam logic [1:0] ACT = 2'b00;
  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;
  localparam logic [1:0] PRE = 2'b11;

  typedef struct packed {
    logic [1:0] cmd;
    logic [2:0] bank;
    logic [6:0] row;
    logic [2:0] col;
    logic       rb;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [2:0] req_bank = '0;
  logic [6:0] req_row = '0;
  logic [2:0] req_col = '0;
  logic       done;
  logic       cmd_req;
  logic       cmd_ack = 1'b0;
  logic [1:0] cmd;
  logic [2:0] bank_id;
  logic [6:0] row_id;
  logic [2:0] col_id;
  logic [7:0] open_mask;
  logic       ref_busy;

  int   n_assert = 0;
  int   n_fail = 0;
  ent_t exp_q[$];
  int   done_exp = 0;
  int   tb_cnt = 0;
  logic [7:0] tb_open = '0;
  logic [6:0] tb_row [8];
  logic prev_req = 1'b0;
  logic req_d = 1'b0;
  int   hold_cnt = 0;
  logic in_hold = 1'b0;

  always #5 clk = ~clk;

  dram_cmd_sched #(
    .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8), .REF_INTERVAL(64)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .done(done), .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd(cmd),
    .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
    .open_mask(open_mask), .ref_busy(ref_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] c, input int b, input int r, input int k, input logic rb);
    ent_t e;
    e.cmd  = c;
    e.bank = 3'(b);
    e.row  = 7'(r);
    e.col  = 3'(k);
    e.rb   = rb;
    exp_q.push_back(e);
  endtask

  // Expected command sequence for one access, from the bench's view of open rows.
  task automatic push_access(input logic rw, input int b, input int r, input int k);
    if (tb_open[b] && tb_row[b] == 7'(r)) begin
      push(rw ? WR : RD, b, 0, k, 1'b0);
    end else begin
      if (tb_open[b]) push(PRE, b, 0, 0, 1'b0);
      push(ACT, b, r, 0, 1'b0);
      push(rw ? WR : RD, b, 0, k, 1'b0);
      tb_open[b] = 1'b1;
      tb_row[b]  = 7'(r);
    end
  endtask

  task automatic do_req(input logic rw, input int b, input int r, input int k);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
    push_access(rw, b, r, k);
    req_rw    = rw;
    req_bank  = 3'(b);
    req_row   = 7'(r);
    req_col   = 3'(k);
    req_valid = 1'b1;
    done_exp++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 300);
    chk(tag, done, 1'b1);
    chk("no_ref_at_done", ref_busy, 1'b0);
  endtask

  // Bench refresh counter: a wrap queues a PRE for every bank open at that point.
  always @(posedge clk) begin
    if (!rst_b) begin
      tb_cnt = 0;
    end else if (tb_cnt == 63) begin
      tb_cnt = 0;
      for (int b = 0; b < 8; b++) begin
        if (tb_open[b]) push(PRE, b, 0, 0, 1'b1);
      end
      tb_open = '0;
    end else begin
      tb_cnt++;
    end
  end

  // Command monitor followed by the DRAM ack responder.
  always @(negedge clk) begin
    ent_t obs;
    ent_t e;
    if (!rst_b) begin
      prev_req = 1'b0;
    end else begin
      if (in_hold) chk("no_cmd_while_ack_high", cmd_req, 1'b0);
      if (cmd_req && !prev_req) begin
        obs = '{cmd, bank_id, row_id, col_id, ref_busy};
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL unexpected_cmd: observed %0h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          chk("cmd", 32'(obs), 32'(e));
        end
      end
      if (done) begin
        chk("done_expected", 32'(done_exp > 0), 1);
        if (done_exp > 0) done_exp--;
      end
      prev_req = cmd_req;
    end
    in_hold = 1'b0;
    if (cmd_ack && !req_d && hold_cnt > 0) begin
      hold_cnt--;
      in_hold = 1'b1;
    end else begin
      cmd_ack = req_d;
    end
    req_d = cmd_req;
  end

  initial begin
    int t;
    foreach (tb_row[i]) tb_row[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_req", cmd_req, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_open_mask", open_mask, 8'h00);
    chk("rst_ref_busy", ref_busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cmd_addr", {cmd, bank_id, row_id, col_id}, 15'h0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1'b1);

    // Closed-bank write: ACT(2,5), WR(2,3)
    do_req(1'b1, 2, 5, 3);
    wait_done("done_closed_write");
    chk("mask_after_write", open_mask, 8'h04);

    // Row hit: only RD
    do_req(1'b0, 2, 5, 6);
    wait_done("done_row_hit");

    // Row miss: PRE(2), ACT(2,9), RD
    do_req(1'b0, 2, 9, 1);
    wait_done("done_row_miss");
    chk("mask_after_miss", open_mask, 8'h04);

    // Reset while a command is being issued
    do_req(1'b0, 4, 1, 0);
    t = 0;
    while (!cmd_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_req_before_reset", cmd_req, 1'b1);
    rst_b = 1'b0;
    #1;
    chk("cmd_req_async_clear", cmd_req, 1'b0);
    chk("mask_async_clear", open_mask, 8'h00);
    exp_q.delete();
    done_exp = 0;
    tb_open  = '0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", done, 1'b0);
    end

    // Open banks 1 and 6, then let the refresh sweep close them
    do_req(1'b1, 1, 3, 2);
    wait_done("done_open_b1");
    do_req(1'b0, 6, 7, 4);
    wait_done("done_open_b6");
    chk("mask_b1_b6", open_mask, 8'h42);
    t = 0;
    while (!ref_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_started", ref_busy, 1'b1);
    push_access(1'b0, 0, 1, 2);
    req_rw = 1'b0; req_bank = 3'd0; req_row = 7'd1; req_col = 3'd2;
    req_valid = 1'b1;
    done_exp++;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_after_sweep", req_ready, 1'b1);
    chk("mask_after_sweep", open_mask, 8'h00);
    chk("ref_busy_after_sweep", ref_busy, 1'b0);
    chk("sweep_cmds_consumed", exp_q.size(), 2);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done("done_after_sweep");

    // Refresh wrap in the middle of a PRE/ACT/RD sequence
    t = 0;
    while (tb_cnt != 54 && t < 200) begin
      @(negedge clk);
      t++;
    end
    do_req(1'b0, 0, 2, 4);
    wait_done("done_during_wrap");
    t = 0;
    while (!ref_busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_after_access", ref_busy, 1'b1);
    t = 0;
    while (ref_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_end", ref_busy, 1'b0);
    chk("mask_after_wrap_sweep", open_mask, 8'h00);

    // Ack held high for 5 extra cycles in RELEASE
    hold_cnt = 5;
    do_req(1'b1, 5, 3, 1);
    wait_done("done_stuck_ack");
    chk("hold_consumed", hold_cnt, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_all_seen", done_exp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
